// File: rtl/urv_dm_arbiter.sv
// ---------------------------------------------------------------------------
// urv_dm_arbiter
//
// Shares one single-outstanding data-memory bus between the uRV data port
// (CPU) and a host master (debug / DMA / loader). One access is in flight at a
// time. Contention is resolved round-robin, and an access whose bus ack never
// arrives is aborted after g_timeout cycles so neither master can hang.
//
// Parameters
//   g_timeout    mem_ack_i wait cycles before abort (1..65535, 0 = never abort)
//   g_cpu_first  grantee on the first contention after reset (1 = CPU, 0 = host)
//
// Ports
//   clk_i, rst_n_i                  clock (rising edge), async active-low reset
//   cpu_addr_i/wdata_i/sel_i        CPU access fields, valid with a request
//   cpu_load_i, cpu_store_i         CPU request levels, held until cpu_ready_o
//   cpu_ready_o                     CPU request accepted this cycle (comb.)
//   cpu_rdata_o                     load data, valid with cpu_load_done_o
//   cpu_load_done_o/store_done_o    one-cycle completion pulses
//   host_addr_i/wdata_i/sel_i/we_i  host access fields
//   host_req_i                      host request level, held until host_ack_o
//   host_ack_o, host_rdata_o        one-cycle completion pulse, read data
//   host_err_o                      with host_ack_o: the access timed out
//   mem_addr_o/wdata_o/sel_o/we_o   registered bus fields
//   mem_req_o                       bus request, held until mem_ack_i or abort
//   mem_rdata_i, mem_ack_i          bus read data and one-cycle completion
//   timeout_o                       one-cycle pulse when an access is aborted
// ---------------------------------------------------------------------------
module urv_dm_arbiter #(
    parameter int unsigned g_timeout   = 255,
    parameter bit          g_cpu_first = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic        cpu_load_i,
    input  logic        cpu_store_i,
    output logic        cpu_ready_o,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_load_done_o,
    output logic        cpu_store_done_o,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    input  logic [3:0]  host_sel_i,
    input  logic        host_we_i,
    input  logic        host_req_i,
    output logic        host_ack_o,
    output logic [31:0] host_rdata_o,
    output logic        host_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    output logic        mem_req_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CPU_XFER  = 2'd1,
        ST_HOST_XFER = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam logic [16:0] TIMEOUT_LIM = 17'(g_timeout);
    localparam bit          TIMEOUT_EN  = (g_timeout != 0);

    state_t      state_q, state_d;
    logic        last_host_q, last_host_d;     // 1: host held the last grant
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_req_q, mem_req_d;
    logic        cpu_load_done_q, cpu_load_done_d;
    logic        cpu_store_done_q, cpu_store_done_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        host_ack_q, host_ack_d;
    logic        host_err_q, host_err_d;
    logic [31:0] host_rdata_q, host_rdata_d;
    logic        timeout_q, timeout_d;

    logic        cpu_act;
    logic        grant_cpu;
    logic        grant_host;
    logic        hit_limit;
    logic        cpu_ready_int;
    logic        finish;
    logic        finish_err;
    logic [31:0] finish_data;

    always_comb begin
        state_d          = state_q;
        last_host_d      = last_host_q;
        cnt_d            = cnt_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        mem_sel_d        = mem_sel_q;
        mem_we_d         = mem_we_q;
        mem_req_d        = mem_req_q;
        cpu_rdata_d      = cpu_rdata_q;
        host_rdata_d     = host_rdata_q;
        // Completion flags are single-cycle pulses: they clear unless re-set.
        cpu_load_done_d  = 1'b0;
        cpu_store_done_d = 1'b0;
        host_ack_d       = 1'b0;
        host_err_d       = 1'b0;
        timeout_d        = 1'b0;
        cpu_ready_int    = 1'b0;
        finish           = 1'b0;
        finish_err       = 1'b0;
        finish_data      = 32'h0;

        cpu_act    = cpu_load_i | cpu_store_i;
        // Under contention the master that did not win last time is served.
        grant_cpu  = cpu_act && (!host_req_i || last_host_q);
        grant_host = host_req_i && !grant_cpu;
        // The limit is reached on the cycle that would bring the count to
        // g_timeout; an ack in that same cycle takes precedence.
        hit_limit  = TIMEOUT_EN && (({1'b0, cnt_q} + 17'd1) == TIMEOUT_LIM);

        case (state_q)
            ST_IDLE: begin
                if (grant_cpu) begin
                    cpu_ready_int = 1'b1;
                    mem_addr_d    = cpu_addr_i;
                    mem_wdata_d   = cpu_wdata_i;
                    mem_sel_d     = cpu_sel_i;
                    mem_we_d      = cpu_store_i;   // load+store together acts as a store
                    mem_req_d     = 1'b1;
                    last_host_d   = 1'b0;
                    cnt_d         = 16'h0;
                    state_d       = ST_CPU_XFER;
                end else if (grant_host) begin
                    mem_addr_d    = host_addr_i;
                    mem_wdata_d   = host_wdata_i;
                    mem_sel_d     = host_sel_i;
                    mem_we_d      = host_we_i;
                    mem_req_d     = 1'b1;
                    last_host_d   = 1'b1;
                    cnt_d         = 16'h0;
                    state_d       = ST_HOST_XFER;
                end
            end
            ST_CPU_XFER, ST_HOST_XFER: begin
                if (mem_ack_i) begin
                    finish      = 1'b1;
                    finish_data = mem_rdata_i;
                end else if (hit_limit) begin
                    finish      = 1'b1;
                    finish_err  = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (finish) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Load the completion registers so they are visible during DONE.
        // Read data is updated for reads and for aborts (which return zero);
        // completed writes leave the previous read value in place.
        if (finish) begin
            if (state_q == ST_CPU_XFER) begin
                cpu_store_done_d = mem_we_q;
                cpu_load_done_d  = !mem_we_q;
                if (!mem_we_q || finish_err) begin
                    cpu_rdata_d = finish_data;
                end
            end else begin
                host_ack_d = 1'b1;
                host_err_d = finish_err;
                if (!mem_we_q || finish_err) begin
                    host_rdata_d = finish_data;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_IDLE;
            last_host_q      <= g_cpu_first;   // CPU first means host "won last"
            cnt_q            <= 16'h0;
            mem_addr_q       <= 32'h0;
            mem_wdata_q      <= 32'h0;
            mem_sel_q        <= 4'h0;
            mem_we_q         <= 1'b0;
            mem_req_q        <= 1'b0;
            cpu_load_done_q  <= 1'b0;
            cpu_store_done_q <= 1'b0;
            cpu_rdata_q      <= 32'h0;
            host_ack_q       <= 1'b0;
            host_err_q       <= 1'b0;
            host_rdata_q     <= 32'h0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_host_q      <= last_host_d;
            cnt_q            <= cnt_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_sel_q        <= mem_sel_d;
            mem_we_q         <= mem_we_d;
            mem_req_q        <= mem_req_d;
            cpu_load_done_q  <= cpu_load_done_d;
            cpu_store_done_q <= cpu_store_done_d;
            cpu_rdata_q      <= cpu_rdata_d;
            host_ack_q       <= host_ack_d;
            host_err_q       <= host_err_d;
            host_rdata_q     <= host_rdata_d;
            timeout_q        <= timeout_d;
        end
    end

    // Ready is combinational, so it is also forced low while reset is held.
    assign cpu_ready_o      = cpu_ready_int & rst_n_i;
    assign cpu_rdata_o      = cpu_rdata_q;
    assign cpu_load_done_o  = cpu_load_done_q;
    assign cpu_store_done_o = cpu_store_done_q;
    assign host_ack_o       = host_ack_q;
    assign host_rdata_o     = host_rdata_q;
    assign host_err_o       = host_err_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign mem_sel_o        = mem_sel_q;
    assign mem_we_o         = mem_we_q;
    assign mem_req_o        = mem_req_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_urv_dm_arbiter: self-checking bench for urv_dm_arbiter (g_timeout=8,
// CPU first). Table of single-access vectors, hand-written multi-cycle
// sequences (alternation, async reset, spurious ack) and a randomized run
// checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_urv_dm_arbiter;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic [3:0]  cpu_sel_i;
    logic        cpu_load_i, cpu_store_i;
    logic        cpu_ready_o;
    logic [31:0] cpu_rdata_o;
    logic        cpu_load_done_o, cpu_store_done_o;
    logic [31:0] host_addr_i, host_wdata_i;
    logic [3:0]  host_sel_i;
    logic        host_we_i, host_req_i;
    logic        host_ack_o;
    logic [31:0] host_rdata_o;
    logic        host_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o, mem_req_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    urv_dm_arbiter #(.g_timeout(TMO), .g_cpu_first(1'b1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_sel_i(cpu_sel_i),
        .cpu_load_i(cpu_load_i), .cpu_store_i(cpu_store_i), .cpu_ready_o(cpu_ready_o),
        .cpu_rdata_o(cpu_rdata_o), .cpu_load_done_o(cpu_load_done_o),
        .cpu_store_done_o(cpu_store_done_o),
        .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_sel_i(host_sel_i),
        .host_we_i(host_we_i), .host_req_i(host_req_i), .host_ack_o(host_ack_o),
        .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_we_o(mem_we_o), .mem_req_o(mem_req_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic clear_inputs();
        cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0; cpu_sel_i = 4'h0;
        cpu_load_i = 1'b0;  cpu_store_i = 1'b0;
        host_addr_i = 32'h0; host_wdata_i = 32'h0; host_sel_i = 4'h0;
        host_we_i = 1'b0;   host_req_i = 1'b0;
        mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Single-access vectors
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_host;
        bit          load, store, we;
        logic [31:0] addr, wdata, mem_rdata;
        logic [3:0]  sel;
        int          ack_k;          // ack on k-th cycle of mem_req_o, 0 = never
        int          exp_req;        // cycles mem_req_o is high
        bit          exp_we, exp_ld, exp_sd, exp_ack, exp_err, exp_to, chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(bit h, bit ld, bit st, bit we, logic [31:0] a,
                                logic [31:0] wd, logic [3:0] s, int k, logic [31:0] rd,
                                int er, bit ewe, bit eld, bit esd, bit eack, bit eerr,
                                bit eto, bit crd, logic [31:0] erd);
        vec_t v;
        v.is_host = h; v.load = ld; v.store = st; v.we = we;
        v.addr = a; v.wdata = wd; v.sel = s; v.ack_k = k; v.mem_rdata = rd;
        v.exp_req = er; v.exp_we = ewe; v.exp_ld = eld; v.exp_sd = esd;
        v.exp_ack = eack; v.exp_err = eerr; v.exp_to = eto; v.chk_rdata = crd;
        v.exp_rdata = erd;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int  req_cnt;
        bit  seen_done;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        if (v.is_host) begin
            host_req_i = 1'b1; host_we_i = v.we; host_addr_i = v.addr;
            host_wdata_i = v.wdata; host_sel_i = v.sel;
        end else begin
            cpu_load_i = v.load; cpu_store_i = v.store; cpu_addr_i = v.addr;
            cpu_wdata_i = v.wdata; cpu_sel_i = v.sel;
        end
        @(negedge clk_i);
        chk1($sformatf("vec%0d_ready", idx), cpu_ready_o, !v.is_host);
        req_cnt = 0;
        seen_done = 0;
        for (int c = 1; c <= 14 && !seen_done; c++) begin
            @(posedge clk_i); #1;
            cpu_load_i = 1'b0; cpu_store_i = 1'b0;
            mem_ack_i = (v.ack_k != 0) && (c == v.ack_k);
            mem_rdata_i = mem_ack_i ? v.mem_rdata : 32'hDEAD_BEEF;
            @(negedge clk_i);
            chk1($sformatf("vec%0d_ready_busy", idx), cpu_ready_o, 1'b0);
            if (mem_req_o) begin
                req_cnt++;
                chk1($sformatf("vec%0d_we", idx), mem_we_o, v.exp_we);
                chk32($sformatf("vec%0d_addr", idx), mem_addr_o, v.addr);
                chk32($sformatf("vec%0d_wdata", idx), mem_wdata_o, v.wdata);
                chk32($sformatf("vec%0d_sel", idx), 32'(mem_sel_o), 32'(v.sel));
            end
            if (cpu_load_done_o || cpu_store_done_o || host_ack_o) begin
                seen_done = 1;
                chk1($sformatf("vec%0d_load_done", idx), cpu_load_done_o, v.exp_ld);
                chk1($sformatf("vec%0d_store_done", idx), cpu_store_done_o, v.exp_sd);
                chk1($sformatf("vec%0d_host_ack", idx), host_ack_o, v.exp_ack);
                chk1($sformatf("vec%0d_host_err", idx), host_err_o, v.exp_err);
                chk1($sformatf("vec%0d_timeout", idx), timeout_o, v.exp_to);
                if (v.chk_rdata)
                    chk32($sformatf("vec%0d_rdata", idx),
                          v.is_host ? host_rdata_o : cpu_rdata_o, v.exp_rdata);
            end
        end
        host_req_i = 1'b0;
        mem_ack_i = 1'b0;
        chk1($sformatf("vec%0d_completed", idx), seen_done, 1'b1);
        chk32($sformatf("vec%0d_req_cycles", idx), 32'(req_cnt), 32'(v.exp_req));
        $display("vec %0d: %s addr=%h req_cycles=%0d done=%0b", idx,
                 v.is_host ? "host" : "cpu ", v.addr, req_cnt, seen_done);
    endtask

    // ------------------------------------------------------------------
    // Randomized run with a transaction-level reference model
    // ------------------------------------------------------------------
    task automatic run_random(input int n_cycles);
        bit          m_busy, m_host, m_we, m_to, m_last_host;
        int          m_acc, m_done, m_k, n_txn, kind;
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [3:0]  m_sel;
        bit          cpu_wait, host_wait, saw_ready, saw_cpu_done, saw_host_ack;
        bit          in_win, exp_ready, exp_req, cpu_act, pick_host, at_done;

        m_busy = 0; m_last_host = 1'b1;   // CPU wins the first contention
        m_acc = 0; m_done = 0; m_k = 0; n_txn = 0;
        m_host = 0; m_we = 0; m_to = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_sel = 0;
        cpu_wait = 0; host_wait = 0; saw_ready = 0; saw_cpu_done = 0; saw_host_ack = 0;

        for (int c = 0; c < n_cycles; c++) begin
            @(posedge clk_i); #1;
            // CPU agent: one request at a time, waits for its completion
            if (saw_ready) begin cpu_load_i = 1'b0; cpu_store_i = 1'b0; cpu_wait = 1; end
            if (saw_cpu_done) cpu_wait = 0;
            if (!cpu_wait && !(cpu_load_i || cpu_store_i) && $urandom_range(2) == 0) begin
                kind = int'($urandom_range(2));
                cpu_load_i  = (kind != 1);
                cpu_store_i = (kind != 0);
                cpu_addr_i  = 32'($urandom_range(255)) << 2;
                cpu_wdata_i = $urandom;
                cpu_sel_i   = 4'($urandom_range(1, 15));
            end
            // Host agent: holds until ack, occasionally abandons mid-access
            if (saw_host_ack) begin
                host_req_i = 1'b0; host_wait = 0;
            end else if (host_wait && m_busy && m_host && $urandom_range(3) == 0) begin
                host_req_i = 1'b0;
            end
            if (!host_wait && $urandom_range(2) == 0) begin
                host_req_i   = 1'b1; host_wait = 1;
                host_we_i    = 1'($urandom_range(1));
                host_addr_i  = 32'h8000_0000 | (32'($urandom_range(255)) << 2);
                host_wdata_i = $urandom;
                host_sel_i   = 4'($urandom_range(1, 15));
            end
            // Memory: real ack on the k-th request cycle, junk acks elsewhere
            in_win = m_busy && (c > m_acc) && (c < m_done);
            if (in_win) begin
                mem_ack_i   = (m_k <= TMO) && (c == m_acc + m_k);
                mem_rdata_i = mem_ack_i ? m_rdata : $urandom;
            end else begin
                mem_ack_i   = ($urandom_range(7) == 0);
                mem_rdata_i = $urandom;
            end

            @(negedge clk_i);
            exp_ready = 0;
            if (!m_busy) begin
                cpu_act = cpu_load_i || cpu_store_i;
                if (cpu_act || host_req_i) begin
                    pick_host   = host_req_i && !(cpu_act && m_last_host);
                    m_last_host = pick_host;
                    m_host      = pick_host;
                    m_busy      = 1;
                    m_acc       = c;
                    m_k         = int'($urandom_range(1, 10));
                    m_to        = (m_k > TMO);
                    m_done      = c + (m_to ? TMO : m_k) + 1;
                    m_rdata     = $urandom;
                    m_addr      = pick_host ? host_addr_i  : cpu_addr_i;
                    m_wdata     = pick_host ? host_wdata_i : cpu_wdata_i;
                    m_sel       = pick_host ? host_sel_i   : cpu_sel_i;
                    m_we        = pick_host ? host_we_i    : cpu_store_i;
                    exp_ready   = !pick_host;
                end
            end
            chk1("rnd_ready", cpu_ready_o, exp_ready);
            exp_req = m_busy && (c > m_acc) && (c < m_done);
            chk1("rnd_mem_req", mem_req_o, exp_req);
            if (exp_req) begin
                chk32("rnd_addr", mem_addr_o, m_addr);
                chk32("rnd_wdata", mem_wdata_o, m_wdata);
                chk1("rnd_we", mem_we_o, m_we);
                chk32("rnd_sel", 32'(mem_sel_o), 32'(m_sel));
            end
            at_done = m_busy && (c == m_done);
            chk1("rnd_load_done", cpu_load_done_o, at_done && !m_host && !m_we);
            chk1("rnd_store_done", cpu_store_done_o, at_done && !m_host && m_we);
            chk1("rnd_host_ack", host_ack_o, at_done && m_host);
            chk1("rnd_host_err", host_err_o, at_done && m_host && m_to);
            chk1("rnd_timeout", timeout_o, at_done && m_to);
            if (at_done && !m_we)
                chk32("rnd_rdata", m_host ? host_rdata_o : cpu_rdata_o, m_to ? 32'h0 : m_rdata);
            saw_ready    = cpu_ready_o;
            saw_cpu_done = cpu_load_done_o || cpu_store_done_o;
            saw_host_ack = host_ack_o;
            if (at_done) begin
                n_txn++;
                $display("rnd txn %0d: %s we=%0b addr=%h ack_k=%0d timeout=%0b", n_txn,
                         m_host ? "host" : "cpu ", m_we, m_addr, m_k, m_to);
                m_busy = 0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t vecs[9];

    initial begin
        int  ngrant, nready;
        bit  exp_owner, owner, pend, pend_owner;

        vecs[0] = mk(0, 1, 0, 0, 32'h100, 32'h0,        4'hF, 3, 32'hCAFE_F00D, 3, 0, 1, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        vecs[1] = mk(1, 0, 0, 1, 32'h200, 32'h1234_5678, 4'hF, 2, 32'h0,        2, 1, 0, 0, 1, 0, 0, 0, 32'h0);
        vecs[2] = mk(1, 0, 0, 0, 32'h204, 32'h0,        4'hF, 1, 32'hA5A5_0001, 1, 0, 0, 0, 1, 0, 0, 1, 32'hA5A5_0001);
        vecs[3] = mk(0, 0, 1, 0, 32'h300, 32'h0BAD_C0DE, 4'h3, 1, 32'h0,        1, 1, 0, 1, 0, 0, 0, 0, 32'h0);
        vecs[4] = mk(0, 1, 1, 0, 32'h304, 32'h55AA_55AA, 4'hC, 2, 32'h0,        2, 1, 0, 1, 0, 0, 0, 0, 32'h0);
        vecs[5] = mk(0, 1, 0, 0, 32'h108, 32'h0,        4'hF, 0, 32'h0,        8, 0, 1, 0, 0, 0, 1, 1, 32'h0);
        vecs[6] = mk(1, 0, 0, 0, 32'h208, 32'h0,        4'hF, 8, 32'h7777_1234, 8, 0, 0, 0, 1, 0, 0, 1, 32'h7777_1234);
        vecs[7] = mk(1, 0, 0, 0, 32'h20C, 32'h0,        4'hF, 0, 32'h0,        8, 0, 0, 0, 1, 1, 1, 1, 32'h0);
        vecs[8] = mk(0, 1, 0, 0, 32'h10C, 32'h0,        4'hF, 8, 32'h1111_2222, 8, 0, 1, 0, 0, 0, 0, 1, 32'h1111_2222);

        // Reset state
        rst_n_i = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk32("rst_outputs", {cpu_load_done_o, cpu_store_done_o, host_ack_o, host_err_o,
                              timeout_o, mem_we_o, cpu_ready_o}, 32'h0);
        chk32("rst_cpu_rdata", cpu_rdata_o, 32'h0);
        #1 rst_n_i = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Both masters held from reset, zero-wait memory: strict alternation
        rst_n_i = 1'b0;
        clear_inputs();
        cpu_store_i = 1'b1; cpu_addr_i = 32'h10; cpu_wdata_i = 32'h1; cpu_sel_i = 4'hF;
        host_req_i = 1'b1;  host_addr_i = 32'h20; host_we_i = 1'b0; host_sel_i = 4'hF;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk1("alt_ready_in_reset", cpu_ready_o, 1'b0);
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        exp_owner = 0; pend = 0; pend_owner = 0; ngrant = 0; nready = 0;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) begin @(posedge clk_i); #1; end
            mem_ack_i = mem_req_o;
            @(negedge clk_i);
            if (cpu_ready_o) nready++;
            if (pend) begin
                chk1("alt_store_done", cpu_store_done_o, !pend_owner);
                chk1("alt_host_ack", host_ack_o, pend_owner);
                pend = 0;
            end else begin
                chk1("alt_no_pulse", cpu_store_done_o || host_ack_o, 1'b0);
            end
            if (mem_req_o) begin
                owner = (mem_addr_o == 32'h20);
                chk1("alt_owner", owner, exp_owner);
                $display("alt grant %0d: %s", ngrant, owner ? "host" : "cpu");
                exp_owner = !exp_owner; pend = 1; pend_owner = owner; ngrant++;
            end
        end
        chk32("alt_grants", 32'(ngrant), 32'd5);
        chk32("alt_cpu_ready_count", 32'(nready), 32'd3);

        // Async reset in the middle of a host access
        do_reset();
        @(posedge clk_i); #1;
        host_req_i = 1'b1; host_addr_i = 32'h40; host_we_i = 1'b0; host_sel_i = 4'hF;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk1("rstmid_req_before", mem_req_o, 1'b1);
        @(posedge clk_i); #1 cpu_load_i = 1'b1; cpu_addr_i = 32'h44;
        #2 rst_n_i = 1'b0;
        #1;
        chk1("rstmid_mem_req", mem_req_o, 1'b0);
        chk32("rstmid_mem_addr", mem_addr_o, 32'h0);
        chk32("rstmid_outputs", {cpu_ready_o, cpu_load_done_o, cpu_store_done_o, host_ack_o,
                                 host_err_o, timeout_o, mem_we_o}, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk1("rstmid_no_ack", host_ack_o, 1'b0);
        end
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        chk1("rstmid_cpu_first", cpu_ready_o, 1'b1);
        $display("reset mid-transfer: cpu granted first after release = %0b", cpu_ready_o);

        // Spurious acks while idle must not complete anything
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            mem_ack_i = (c < 3);
            mem_rdata_i = 32'hBAD0_0000 | 32'(c);
            @(negedge clk_i);
            chk32("spur_no_pulse", {cpu_load_done_o, cpu_store_done_o, host_ack_o,
                                    timeout_o, mem_req_o}, 32'h0);
        end
        $display("spurious acks: 3 applied in idle");

        // Randomized traffic against the reference model
        do_reset();
        run_random(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/urv_dm_arbiter.md
Name: urv_dm_arbiter

Overview:
Two-master arbiter that shares one single-outstanding data-memory bus between the uRV data port (CPU) and a host master (debug/DMA/loader).
- Sits between urv_cpu dm_* pins and the SoC data RAM/peripheral bus.
- Issues one transaction at a time, grants round-robin and aborts stuck accesses after a timeout.

Parameters:
g_timeout, 255, mem_ack_i wait cycles before abort; 1..65535; 0 disables the timeout.
g_cpu_first, 1, grantee on the first contention after reset: 1=CPU, 0=host.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset
cpu_addr_i  in  32  CPU address, valid while cpu_load_i/cpu_store_i high
cpu_wdata_i  in  32  CPU store data
cpu_sel_i  in  4  CPU byte select
cpu_load_i  in  1  CPU load request (level, held until cpu_ready_o)
cpu_store_i  in  1  CPU store request (level, held until cpu_ready_o)
cpu_ready_o  out  1  CPU request accepted this cycle (combinational)
cpu_rdata_o  out  32  load data, valid with cpu_load_done_o
cpu_load_done_o  out  1  one-cycle load completion pulse
cpu_store_done_o  out  1  one-cycle store completion pulse
host_addr_i  in  32  host address
host_wdata_i  in  32  host write data
host_sel_i  in  4  host byte select
host_we_i  in  1  host write enable
host_req_i  in  1  host request (level, held until host_ack_o)
host_ack_o  out  1  one-cycle host completion pulse
host_rdata_o  out  32  host read data, valid with host_ack_o
host_err_o  out  1  with host_ack_o: access timed out
mem_addr_o  out  32  bus address (registered)
mem_wdata_o  out  32  bus write data (registered)
mem_sel_o  out  4  bus byte select (registered)
mem_we_o  out  1  bus write enable (registered)
mem_req_o  out  1  bus request, held until mem_ack_i or abort
mem_rdata_i  in  32  bus read data, valid with mem_ack_i
mem_ack_i  in  1  bus completion, one cycle
timeout_o  out  1  one-cycle pulse on abort

Behaviour:
- FSM states: IDLE, CPU_XFER, HOST_XFER, DONE.
- Reset (async, rst_n_i=0):
  - state=IDLE; all outputs 0; timeout counter 0.
  - last_grant = HOST if g_cpu_first=1, else CPU.
  - mem_req_o drops immediately even mid-transfer; the in-flight access is lost and no done/ack is issued.
- IDLE arbitration:
  - cpu_act = cpu_load_i|cpu_store_i.
  - Only one active: that master is granted.
  - Both active: grant the master not equal to last_grant.
  - cpu_ready_o=1 combinationally when CPU is granted in IDLE; never asserted in other states.
  - Host accept is internal; no separate ready.
- Grant edge:
  - Latch addr/wdata/sel into mem_* registers.
  - CPU: mem_we_o=cpu_store_i; load and store both high is treated as a store.
  - Update last_grant.
  - Enter CPU_XFER or HOST_XFER; mem_req_o=1 from the next cycle.
- XFER states:
  - mem_req_o and mem_* stay stable until mem_ack_i.
  - On mem_ack_i: capture mem_rdata_i (reads) into the rdata register, mem_req_o=0, enter DONE.
  - Timeout counter is 16-bit, cleared on grant, increments each XFER cycle without ack.
  - If the counter reaches g_timeout (g_timeout≠0) before ack: mem_req_o=0, timeout_o pulse, rdata=32'h0, err=1, enter DONE.
  - Ack arriving in the same cycle as the limit wins; no timeout.
- DONE (exactly one cycle):
  - CPU grant: cpu_load_done_o or cpu_store_done_o=1 and cpu_rdata_o=captured data. A timed-out CPU access still completes, so the pipeline never hangs.
  - Host grant: host_ack_o=1, host_rdata_o, host_err_o=err.
  - Next state IDLE.
  - Done registers clear the next cycle; cpu_rdata_o/host_rdata_o hold their value until the next completion.
- Latency:
  - Accept cycle N; mem_req_o high N+1..M (ack at M); done/ack pulse at M+1.
  - IDLE re-entered at M+2, next grant possible at M+2.
  - Minimum 3 cycles per access; one access in flight at a time.
- Illegal/boundary cases:
  - host_req_i dropped mid-transfer: transfer completes and host_ack_o pulses anyway.
  - mem_ack_i while not in XFER: ignored.
  - Back-to-back contention alternates strictly CPU, host, CPU, …

Test Plan:
- Reset, then CPU load 0x100 only; memory acks 2 cycles after mem_req_o with 0xCAFEF00D -> cpu_ready_o at N, mem_req_o N+1..N+3, cpu_load_done_o at N+4 with cpu_rdata_o=0xCAFEF00D, mem_we_o=0.
- CPU store and host read both held from reset, zero-wait memory -> CPU granted first (g_cpu_first=1), host second; continuous requests alternate CPU/host and each master's done/ack pulse appears exactly once per access.
- Host write 0x200=0x12345678 sel=4'hF -> mem_we_o=1, mem_wdata_o=0x12345678 stable until ack; host_ack_o one cycle, host_err_o=0, cpu_ready_o=0 throughout.
- g_timeout=8, memory never acks a CPU load -> mem_req_o high for 8 cycles then low; timeout_o pulse; cpu_load_done_o with cpu_rdata_o=0; the next host request is served normally.
- rst_n_i asserted mid-HOST_XFER -> mem_req_o and all outputs 0 immediately with no clock edge; no host_ack_o; after release, the first contention grants the CPU.
- Spurious mem_ack_i in IDLE, ack coinciding with the timeout limit -> no completion pulse for the spurious ack; the coincident ack completes with err=0 and no timeout_o.
